mem_sram_ctrl: RTL and testbench

//  MEM-stage memory port. Replaces the single-cycle data memory with an external 16-bit SRAM.

---
 rtl/arm_pkg.sv | 6 +
 rtl/sram_wait_cnt.sv | 35 +++
 rtl/mem_sram_ctrl.sv | 112 +++++++++++
 tb/tb_mem_sram_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared types and constants for the MEM-stage external SRAM port.
package arm_pkg;
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} sram_state_t;
   localparam int DATA_BASE_ADDR = 1024;
   localparam int SRAM_DW        = 16;
endpackage

// File: rtl/sram_wait_cnt.sv
// Wait-state counter: clear has priority, counts while enabled, saturates at WAIT_CYCLES-1.
// tc flags the last cycle of a half-word access; no wrap beyond the terminal value.
module sram_wait_cnt #(
   parameter int WAIT_CYCLES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam int CW = $clog2(WAIT_CYCLES) + 1;
   localparam logic [CW-1:0] TC_VAL = CW'(WAIT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != TC_VAL)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC_VAL);
endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage port to a 16-bit SRAM: each 32-bit access is two half-word phases of WAIT_CYCLES each.
// ready is low from the request cycle until DONE (2W+1 cycles); inputs are ignored after the IDLE latch.
module mem_sram_ctrl
   import arm_pkg::*;
#(
   parameter int WAIT_CYCLES = 3,
   parameter int BASE_ADDR   = DATA_BASE_ADDR,
   parameter int SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_we_n
);
   localparam int WW = SRAM_AW - 1;

   sram_state_t        state_q, state_d;
   logic               op_wr_q, op_wr_d;
   logic [WW-1:0]      word_q, word_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [SRAM_DW-1:0] lo_q, lo_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               cnt_clr, cnt_en, cnt_tc;
   logic               in_access, half;

   sram_wait_cnt #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .tc_o  (cnt_tc)
   );

   always_comb begin
      state_d = state_q;
      op_wr_d = op_wr_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      lo_d    = lo_q;
      rdata_d = rdata_q;
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
      case (state_q)
         IDLE: begin
            // Write wins when both enables are set; address wraps modulo 2^32 below the base.
            if (wr_en || rd_en) begin
               state_d = LO;
               op_wr_d = wr_en;
               word_d  = WW'((address - 32'(BASE_ADDR)) >> 2);
               wdata_d = write_data;
            end
         end
         LO: begin
            cnt_clr = 1'b0;
            cnt_en  = 1'b1;
            if (cnt_tc) begin
               lo_d    = sram_dq_in;
               cnt_clr = 1'b1;
               state_d = HI;
            end
         end
         HI: begin
            cnt_clr = 1'b0;
            cnt_en  = 1'b1;
            if (cnt_tc) begin
               if (!op_wr_q) begin
                  rdata_d = {sram_dq_in, lo_q};
               end
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_wr_q <= 1'b0;
         word_q  <= '0;
         wdata_q <= '0;
         lo_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_wr_q <= op_wr_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         lo_q    <= lo_d;
         rdata_q <= rdata_d;
      end
   end

   assign in_access   = (state_q == LO) || (state_q == HI);
   assign half        = (state_q == HI);
   assign ready       = (state_q == DONE) || ((state_q == IDLE) && !wr_en && !rd_en);
   assign sram_addr   = in_access ? {word_q, half} : '0;
   assign sram_dq_oe  = in_access && op_wr_q;
   assign sram_we_n   = !sram_dq_oe;
   assign sram_dq_out = !sram_dq_oe ? '0 : (half ? wdata_q[31:16] : wdata_q[15:0]);
   assign read_data   = rdata_q;
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench: stimulus pushes expected access traces, a negedge monitor pops and compares.
module tb_mem_sram_ctrl;
   localparam int W    = 3;
   localparam int BASE = 1024;
   localparam int AW   = 18;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0, rd_en = 1'b0;
   logic [31:0]   address = '0, write_data = '0;
   logic [31:0]   read_data;
   logic          ready;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_out, sram_dq_in;
   logic          sram_dq_oe, sram_we_n;

   always #5 clk = ~clk;

   mem_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .SRAM_AW(AW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
   );

   // Behavioural SRAM: zero-latency read, write on the clock edge while we_n is low.
   logic [15:0] sram_mem [0:(1<<AW)-1];
   assign sram_dq_in = sram_mem[sram_addr];
   always @(posedge clk) begin
      if (sram_we_n === 1'b0) sram_mem[sram_addr] <= sram_dq_out;
   end

   function automatic logic [15:0] pat(input int unsigned hw);
      return 16'((hw * 32'd40503) ^ 32'h5A5A);
   endfunction

   typedef struct {
      bit          is_wr;
      int unsigned hw_lo;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } txn_t;

   int          n_chk = 0, n_fail = 0;
   txn_t        sb_q[$];
   txn_t        cur;
   bit          mon_active = 0;
   int          mon_k = 0;
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] last_rd = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: 32-bit word memory indexed by (address-BASE)/4 modulo the SRAM word space.
   task automatic model_push(input bit wr, input logic [31:0] addr, input logic [31:0] data);
      txn_t        t;
      int unsigned word;
      word    = ((addr - 32'(BASE)) >> 2) & ((1 << (AW - 1)) - 1);
      t.is_wr = wr;
      t.hw_lo = word * 2;
      t.wdata = data;
      if (wr) begin
         ref_mem[word] = data;
         t.exp_rd      = last_rd;
      end else begin
         t.exp_rd = ref_mem.exists(word) ? ref_mem[word] : {pat(word * 2 + 1), pat(word * 2)};
         last_rd  = t.exp_rd;
      end
      sb_q.push_back(t);
   endtask

   // gmode: 0 inputs held, 1 address->BASE and rd_en dropped at t=2, 2 inputs scrambled every stall cycle.
   task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] data, input int gmode);
      int n;
      bit done;
      model_push(wr, addr, data);
      wr_en = wr; rd_en = rd; address = addr; write_data = data;
      n = 0; done = 0;
      while (!done) begin
         @(negedge clk);
         n++;
         if (ready === 1'b1 && n > 1) begin
            done = 1;
         end else if (n >= 40) begin
            n_chk++; n_fail++;
            $display("FAIL access_timeout: ready still %b after %0d cycles, expected 1 after %0d", ready, n, 2*W+1);
            done = 1;
         end else if (gmode == 1 && n == 3) begin
            address = 32'(BASE);
            rd_en   = 1'b0;
         end else if (gmode == 2 && n >= 2) begin
            wr_en      = 1'($urandom_range(0, 1));
            rd_en      = 1'($urandom_range(0, 1));
            address    = $urandom;
            write_data = $urandom;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      wr_en = 1'b0; rd_en = 1'b0; address = $urandom; write_data = $urandom;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic reset_check();
      @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_read_data", read_data, 32'd0);
      chk("rst_sram_addr", 32'(sram_addr), 32'd0);
      chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
      @(posedge clk); #1;
   endtask

   // Monitor: cycle k=0 is the request cycle, 1..W low half, W+1..2W high half, 2W+1 DONE.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_active = 0;
         end else if (!mon_active) begin
            if (ready === 1'b0) begin
               if (sb_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected_stall: ready=%b with no access issued, expected 1", ready);
               end else begin
                  cur        = sb_q.pop_front();
                  mon_active = 1;
                  mon_k      = 0;
                  chk("req_we_n", 32'(sram_we_n), 32'd1);
                  chk("req_oe", 32'(sram_dq_oe), 32'd0);
               end
            end else begin
               chk("idle_we_n", 32'(sram_we_n), 32'd1);
               chk("idle_oe", 32'(sram_dq_oe), 32'd0);
            end
         end else begin
            mon_k++;
            if (ready === 1'b1) begin
               chk("stall_cycles", 32'(mon_k), 32'(2*W+1));
               chk("done_read_data", read_data, cur.exp_rd);
               chk("done_we_n", 32'(sram_we_n), 32'd1);
               mon_active = 0;
            end else if (mon_k <= 2*W) begin
               chk("sram_addr", 32'(sram_addr), cur.hw_lo + ((mon_k > W) ? 1 : 0));
               chk("we_n", 32'(sram_we_n), cur.is_wr ? 32'd0 : 32'd1);
               chk("oe", 32'(sram_dq_oe), cur.is_wr ? 32'd1 : 32'd0);
               if (cur.is_wr)
                  chk("dq_out", 32'(sram_dq_out),
                      (mon_k > W) ? 32'(cur.wdata[31:16]) : 32'(cur.wdata[15:0]));
            end else if (mon_k == 2*W+1) begin
               chk("done_ready", 32'(ready), 32'd1);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          r;
      bit          wr, rd;
      logic [31:0] addr;
      for (int i = 0; i < (1 << AW); i++) sram_mem[i] = pat(i);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      reset_check();

      access(1'b1, 1'b0, 32'(BASE + 8), 32'hDEAD_BEEF, 0);
      idle(2);
      access(1'b0, 1'b1, 32'(BASE + 8), 32'h0, 0);
      idle(1);

      // Load aborted by a 2-cycle reset in the low phase.
      model_push(1'b0, 32'(BASE + 8), 32'h0);
      rd_en = 1'b1; address = 32'(BASE + 8);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; rd_en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      last_rd = '0;
      reset_check();

      access(1'b0, 1'b1, 32'(BASE + 8), 32'h0, 0);
      access(1'b1, 1'b1, 32'(BASE + 16), 32'h1234_5678, 0);
      idle(1);
      access(1'b0, 1'b1, 32'(BASE + 16), 32'h0, 0);
      idle(1);
      access(1'b0, 1'b1, 32'(BASE + 8), 32'h0, 1);
      idle(1);

      access(1'b0, 1'b1, 32'(BASE + 16), 32'h0, 0);
      access(1'b1, 1'b0, 32'(BASE + 24), 32'h55AA_33CC, 0);
      access(1'b0, 1'b1, 32'(BASE + 24), 32'h0, 0);
      idle(1);

      access(1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 0);
      access(1'b0, 1'b1, 32'h0, 32'h0, 0);
      access(1'b0, 1'b1, 32'h4, 32'h0, 0);
      idle(2);

      for (int i = 0; i < 40; i++) begin
         r    = $urandom_range(0, 9);
         addr = (r == 0) ? $urandom : 32'(BASE + 4 * $urandom_range(0, 15));
         wr   = 1'($urandom_range(0, 1));
         rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         access(wr, rd, addr, $urandom, 2 * $urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end

      idle(5);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      chk("monitor_idle", 32'(mon_active), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
